// File: rtl/serial_sub_pkg.sv
// Shared constants and FSM state encoding for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational single-bit full subtractor: {bo,d} = a - b - bi.
module serial_sub_cell (
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b,
  input  logic bi
);

  // Two-bit arithmetic: a negative result wraps so that bit 1 is the borrow.
  assign {bo, d} = {1'b0, a} - {1'b0, b} - {1'b0, bi};

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-2:0]   res_sr;
  logic               borrow_q;
  logic [CNT_W-1:0]   count;
  logic               cell_d;
  logic               cell_bo;
  logic [WIDTH-1:0]   res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic               a_msb;
  logic               b_msb;
`endif

  serial_sub_cell u_cell (
    .d  (cell_d),
    .bo (cell_bo),
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow_q)
  );

  // Partial result lives only in res_sr; diff is written once per operation.
  assign res_next = {cell_d, res_sr};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain shifts within one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            state    <= ST_RUN;
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        ST_RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          res_sr   <= res_next[WIDTH-1:1];
          borrow_q <= cell_bo;
          count    <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Present operands with start for exactly one accepting edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle index (negedges after the accepting edge) of the done pulse; -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b, want all 0", busy, done, diff, borrow_out);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
`endif
  endtask

  task automatic test_basic;
    int lat, bc;
    launch(8'd5, 8'd3);
    a = 8'hAA;  // changing operands after acceptance must not matter
    b = 8'h55;
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++;
    if (bc !== 8) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    n_cmp++;
    if ({diff, borrow_out} !== {8'h02, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_result: got diff=%h bo=%b want diff=02 bo=0", diff, borrow_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, diff} !== {1'b0, 8'h02}) begin
      n_bad++;
      $display("FAIL basic_hold: got done=%b diff=%h want done=0 diff=02", done, diff);
    end
  endtask

  task automatic test_borrow;
    logic [7:0] va [3] = '{8'd3, 8'd0, 8'h00};
    logic [7:0] vb [3] = '{8'd5, 8'd0, 8'hFF};
    logic [8:0] ve [3] = '{{1'b1, 8'hFE}, {1'b0, 8'h00}, {1'b1, 8'h01}};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      wait_done(lat, bc);
      n_cmp++;
      if (lat !== 9 || {borrow_out, diff} !== ve[i]) begin
        n_bad++;
        $display("FAIL borrow_vec%0d: got lat=%0d bo=%b diff=%h want lat=9 bo=%b diff=%h",
                 i, lat, borrow_out, diff, ve[i][8], ve[i][7:0]);
      end
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    launch(8'h80, 8'h01);
    wait_done(lat, bc);
    n_cmp++;
    if ({borrow_out, diff} !== {1'b0, 8'h7F}) begin
      n_bad++;
      $display("FAIL ovf_80_01_result: got bo=%b diff=%h want bo=0 diff=7f", borrow_out, diff);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_80_01_flag: got %b want 1", overflow); end
`endif
    launch(8'h7F, 8'h01);
    wait_done(lat, bc);
    n_cmp++;
    if ({borrow_out, diff} !== {1'b0, 8'h7E}) begin
      n_bad++;
      $display("FAIL ovf_7f_01_result: got bo=%b diff=%h want bo=0 diff=7e", borrow_out, diff);
    end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_7f_01_flag: got %b want 0", overflow); end
`endif
  endtask

  task automatic test_ignore_start;
    int first = -1;
    int dones = 0;
    logic [7:0] d_first = 'x;
    launch(8'h10, 8'h01);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3) begin
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (first < 0) begin
          first = n;
          d_first = diff;
        end
      end
    end
    n_cmp++;
    if (dones !== 1 || first !== 9) begin
      n_bad++;
      $display("FAIL ignore_start_pulses: got %0d done(s), first at %0d, want 1 at 9", dones, first);
    end
    n_cmp++;
    if (d_first !== 8'h0F) begin n_bad++; $display("FAIL ignore_start_result: got %h want 0f", d_first); end
  endtask

  task automatic test_abort;
    int dones = 0;
    int lat, bc;
    launch(8'h20, 8'h03);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, diff, borrow_out} !== 11'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bo=%b want all 0", busy, done, diff, borrow_out);
    end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d done(s) want 0", dones); end
    launch(8'h40, 8'h01);
    wait_done(lat, bc);
    n_cmp++;
    if (lat !== 9 || diff !== 8'h3F) begin
      n_bad++;
      $display("FAIL abort_restart: got lat=%0d diff=%h want lat=9 diff=3f", lat, diff);
    end
  endtask

  task automatic test_back_to_back;
    int t1 = -1;
    int t2 = -1;
    logic [7:0] d1 = 'x;
    logic [7:0] d2 = 'x;
    logic [7:0] d_mid = 'x;
    logic       bo2 = 'x;
    @(negedge clk);
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 13) d_mid = diff;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          d1 = diff;
          a = 8'd2;
          b = 8'd7;
        end else if (t2 < 0) begin
          t2 = n;
          d2 = diff;
          bo2 = borrow_out;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (t1 !== 9 || t2 - t1 !== 9) begin
      n_bad++;
      $display("FAIL b2b_timing: got done at %0d and %0d, want 9 and 18", t1, t2);
    end
    n_cmp++;
    if (d1 !== 8'h05) begin n_bad++; $display("FAIL b2b_first: got %h want 05", d1); end
    n_cmp++;
    if (d_mid !== 8'h05) begin n_bad++; $display("FAIL b2b_hold_midrun: got %h want 05", d_mid); end
    n_cmp++;
    if ({bo2, d2} !== {1'b1, 8'hFB}) begin
      n_bad++;
      $display("FAIL b2b_second: got bo=%b diff=%h want bo=1 diff=fb", bo2, d2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
